prefix_adder_seq: RTL and testbench

- Sequential, area-reduced parallel-prefix adder.
- Time-multiplexes one row of WIDTH prefix cells over log2(WIDTH) levels, in Kogge-Stone spacing.
- A controller FSM sequences operand capture, the prefix levels and sum formation.
- Sits beside the combinational prefix adders as a low-area option with valid/ready handshakes on both sides.

---
 rtl/prefix_pkg.sv | 19 +
 rtl/prefix_adder_seq_if.sv | 28 ++
 rtl/prefix_black_cell.sv | 12 +
 rtl/prefix_adder_seq.sv | 144 ++++++++++++++
 tb/tb_prefix_adder_seq.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/prefix_pkg.sv
// Shared types and sizing helpers for the sequential Kogge-Stone prefix adder.
package prefix_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic int levels_f(input int width);
        return $clog2(width);
    endfunction

    // The counter also steps through one extra value, LEVELS, which is the sum-forming cycle.
    function automatic int lvl_w_f(input int width);
        return $clog2(levels_f(width) + 1);
    endfunction

endpackage

// File: rtl/prefix_adder_seq_if.sv
// Operand/result handshake bundle for prefix_adder_seq; sub/ovf exist only with PREFIX_ADDER_SUB_EN.
interface prefix_adder_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PREFIX_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/prefix_black_cell.sv
// Generate/propagate combining cell used at every bit of the shared prefix row.
module prefix_black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;
endmodule

// File: rtl/prefix_adder_seq.sv
// Area-reduced adder: one row of prefix cells reused over log2(WIDTH) levels.
// Optional subtract mode and signed-overflow flag when PREFIX_ADDER_SUB_EN is defined.
module prefix_adder_seq
    import prefix_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    prefix_adder_seq_if.slave  bus
);
    localparam int LEVELS = levels_f(WIDTH);
    localparam int LVL_W  = lvl_w_f(WIDTH);

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [WIDTH-1:0]   g_q, g_d, p_q, p_d, p0_q, p0_d, sum_q, sum_d;
    logic               cin_q, cin_d, cout_q, cout_d;
    logic [WIDTH-1:0]   g_cell, p_cell, cell_en;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

`ifdef PREFIX_ADDER_SUB_EN
    logic ovf_q, ovf_d;
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub | bus.cin;
    assign bus.ovf = ovf_q;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // lo-side operand for each level: G/P at distance 2^k, or disabled where i < 2^k.
    // Entry LEVELS is the sum-forming cycle, where no cell result is taken.
    for (genvar i = 0; i < WIDTH; i++) begin : g_col
        logic [LEVELS:0] lo_g, lo_p, lo_en;
        for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
            if (i >= (1 << k)) begin : g_has
                assign lo_g[k]  = g_q[i - (1 << k)];
                assign lo_p[k]  = p_q[i - (1 << k)];
                assign lo_en[k] = 1'b1;
            end else begin : g_none
                assign lo_g[k]  = 1'b0;
                assign lo_p[k]  = 1'b0;
                assign lo_en[k] = 1'b0;
            end
        end
        assign lo_g[LEVELS]  = 1'b0;
        assign lo_p[LEVELS]  = 1'b0;
        assign lo_en[LEVELS] = 1'b0;

        prefix_black_cell u_cell (
            .g_hi  (g_q[i]),
            .p_hi  (p_q[i]),
            .g_lo  (lo_g[lvl_q]),
            .p_lo  (lo_p[lvl_q]),
            .g_out (g_cell[i]),
            .p_out (p_cell[i])
        );
        assign cell_en[i] = lo_en[lvl_q];
    end

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        g_d     = g_q;
        p_d     = p_q;
        p0_d    = p0_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef PREFIX_ADDER_SUB_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    p0_d    = bus.a ^ b_eff;
                    p_d     = bus.a ^ b_eff;
                    g_d     = bus.a & b_eff;
                    g_d[0]  = (bus.a[0] & b_eff[0]) | ((bus.a[0] ^ b_eff[0]) & cin_eff);
                    cin_d   = cin_eff;
                    lvl_d   = '0;
                    state_d = PREFIX;
                end
            end
            PREFIX: begin
                if (lvl_q == LVL_W'(LEVELS)) begin
                    // G now holds the carry out of each bit position.
                    sum_d   = p0_q ^ {g_q[WIDTH-2:0], cin_q};
                    cout_d  = g_q[WIDTH-1];
`ifdef PREFIX_ADDER_SUB_EN
                    ovf_d   = g_q[WIDTH-2] ^ g_q[WIDTH-1];
`endif
                    state_d = DONE;
                end else begin
                    g_d   = (g_cell & cell_en) | (g_q & ~cell_en);
                    p_d   = (p_cell & cell_en) | (p_q & ~cell_en);
                    lvl_d = lvl_q + LVL_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            g_q     <= '0;
            p_q     <= '0;
            p0_q    <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef PREFIX_ADDER_SUB_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            g_q     <= g_d;
            p_q     <= p_d;
            p0_q    <= p0_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef PREFIX_ADDER_SUB_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_prefix_adder_seq.sv
// Self-checking bench for prefix_adder_seq (WIDTH=16): directed table, corner sequences, random ops.
module tb_prefix_adder_seq;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    int   n_done = 0;

    prefix_adder_seq_if #(.WIDTH(16)) bus ();

    prefix_adder_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) n_acc++;
            if (bus.out_valid && bus.out_ready) n_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic; returns {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [15:0] bb;
        logic        cc;
        logic [16:0] r;
        logic        ov;
        bb = sb ? ~b : b;
        cc = sb ? 1'b1 : ci;
        r  = {1'b0, a} + {1'b0, bb} + {16'd0, cc};
        ov = (a[15] == bb[15]) && (r[15] != a[15]);
        return {ov, r};
    endfunction

    task automatic set_sub(input logic sb);
`ifdef PREFIX_ADDER_SUB_EN
        bus.sub = sb;
`else
        if (sb) $display("note: subtract requested in add-only build");
`endif
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a; bus.b = b; bus.cin = ci;
        set_sub(sb);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
        set_sub(1'b0);
        chk("busy_ready", {31'd0, bus.in_ready}, 32'd0);
    endtask

    task automatic finish_op(input int stall, output logic [15:0] s, output logic c, output logic o);
        int n;
        for (n = 1; n <= 20; n++) begin
            bus.out_ready = 1'($urandom);
            @(posedge clk); #1;
            if (bus.out_valid) break;
        end
        bus.out_ready = 1'b0;
        chk("latency", n, 5);
        s = bus.sum;
        c = bus.cout;
`ifdef PREFIX_ADDER_SUB_EN
        o = bus.ovf;
`else
        o = 1'b0;
`endif
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = 1'b1; bus.a = 16'd1; bus.b = 16'd1;
            @(posedge clk); #1;
            chk("stall_sum", {16'd0, bus.sum}, {16'd0, s});
            chk("stall_cout", {31'd0, bus.cout}, {31'd0, c});
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("drop_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ready_back", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] s;
        logic        c, o;
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc, rs;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        set_sub(1'b0);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum", {16'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            finish_op(0, s, c, o);
            chk("vec_sum", {16'd0, s}, {16'd0, vecs[i].s});
            chk("vec_cout", {31'd0, c}, {31'd0, vecs[i].c});
        end

        // Backpressure: result held while stalled; in_valid pulses during DONE are not accepted.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        finish_op(3, s, c, o);
        chk("bp_sum", {16'd0, s}, 32'h0000_1010);
        chk("bp_cout", {31'd0, c}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("bp_no_accept", {31'd0, bus.in_ready}, 32'd1);
            chk("bp_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Reset while the level counter sits at 2.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rmid_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rmid_sum", {16'd0, bus.sum}, 32'd0);
        chk("rmid_cout", {31'd0, bus.cout}, 32'd0);
        chk("rmid_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rpost_ready", {31'd0, bus.in_ready}, 32'd1);
        start_op(16'd3, 16'd4, 1'b0, 1'b0);
        finish_op(0, s, c, o);
        chk("rpost_sum", {16'd0, s}, 32'd7);

`ifdef PREFIX_ADDER_SUB_EN
        start_op(16'd5, 16'd7, 1'b0, 1'b1);
        finish_op(0, s, c, o);
        chk("sub1_sum", {16'd0, s}, 32'h0000_FFFE);
        chk("sub1_cout", {31'd0, c}, 32'd0);
        chk("sub1_ovf", {31'd0, o}, 32'd0);
        start_op(16'h8000, 16'd1, 1'b0, 1'b1);
        finish_op(1, s, c, o);
        chk("sub2_sum", {16'd0, s}, 32'h0000_7FFF);
        chk("sub2_cout", {31'd0, c}, 32'd1);
        chk("sub2_ovf", {31'd0, o}, 32'd1);
`endif

        for (int k = 0; k < 2000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef PREFIX_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            start_op(ra, rb, rc, rs);
            finish_op(int'($urandom_range(0, 3)), s, c, o);
            m = model(ra, rb, rc, rs);
            chk("rand_sum", {16'd0, s}, {16'd0, m[15:0]});
            chk("rand_cout", {31'd0, c}, {31'd0, m[16]});
`ifdef PREFIX_ADDER_SUB_EN
            chk("rand_ovf", {31'd0, o}, {31'd0, m[17]});
`endif
        end

        // Exactly one result per accept; the reset-aborted operation produced none.
        chk("one_out_per_accept", n_done, n_acc - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
